axi4lite_reg_slave: RTL and testbench

AXI4LITE_REG_SLAVE -- requirements
Module: axi4lite_reg_slave

---
 rtl/axi4lite_reg_pkg.sv | 32 +++
 rtl/axi4lite_reg_slave.sv | 224 ++++++++++++++++++++++
 tb/tb_axi4lite_reg_slave.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_reg_pkg.sv
// Shared response codes, channel state encodings and byte-strobe merge helper
// for the AXI4-Lite register slave.
package axi4lite_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_t;

  // Merge new_val into old_val, one byte lane per strobe bit.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave exposing C_NUM_REGS read/write 32-bit registers with
// per-register write strobes; independent write and read channel FSMs.
module axi4lite_reg_slave
  import axi4lite_reg_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 5,
  parameter int C_NUM_REGS   = 4
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic [C_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                         S_AXI_AWPROT,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_out,
  output logic [C_NUM_REGS-1:0]              reg_wr_pulse
);

  localparam int IDX_W = C_ADDR_WIDTH - 2;

  typedef logic [C_DATA_WIDTH-1:0]   word_t;
  typedef logic [IDX_W-1:0]          idx_t;
  typedef logic [C_DATA_WIDTH/8-1:0] strb_t;
  typedef logic [C_NUM_REGS-1:0]     sel_t;

  // One-hot register select; all zeros means the word index is unmapped.
  function automatic sel_t decode(input idx_t idx);
    sel_t sel;
    sel = '0;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      if (idx == idx_t'(k)) sel[k] = 1'b1;
    end
    return sel;
  endfunction

  word_t    regs [C_NUM_REGS];

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  idx_t     aw_idx_in, ar_idx_in, aw_idx_q, commit_idx;
  word_t    w_data_q, commit_data, rd_word;
  strb_t    w_strb_q, commit_strb;
  sel_t     commit_sel, rd_sel;
  logic     commit, capture_aw, capture_w, ar_fire;
  logic     aw_ready, w_ready, ar_ready;
  logic [1:0] bresp_q, rresp_q;
  word_t    rdata_q;

  assign aw_idx_in = S_AXI_AWADDR[C_ADDR_WIDTH-1:2];
  assign ar_idx_in = S_AXI_ARADDR[C_ADDR_WIDTH-1:2];

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // ---------------------------------------------------------------- write FSM
  // NOTE: state flops use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next      = w_state;
    aw_ready    = 1'b0;
    w_ready     = 1'b0;
    commit      = 1'b0;
    capture_aw  = 1'b0;
    capture_w   = 1'b0;
    commit_idx  = aw_idx_q;
    commit_data = w_data_q;
    commit_strb = w_strb_q;
    if (!ARESET) begin
      unique case (w_state)
        W_IDLE: begin
          aw_ready = 1'b1;
          w_ready  = 1'b1;
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            commit      = 1'b1;
            commit_idx  = aw_idx_in;
            commit_data = S_AXI_WDATA;
            commit_strb = S_AXI_WSTRB;
            w_next      = W_RESP;
          end else if (S_AXI_AWVALID) begin
            capture_aw = 1'b1;
            w_next     = W_HAVE_ADDR;
          end else if (S_AXI_WVALID) begin
            capture_w = 1'b1;
            w_next    = W_HAVE_DATA;
          end
        end
        W_HAVE_ADDR: begin
          w_ready = 1'b1;
          if (S_AXI_WVALID) begin
            commit      = 1'b1;
            commit_data = S_AXI_WDATA;
            commit_strb = S_AXI_WSTRB;
            w_next      = W_RESP;
          end
        end
        W_HAVE_DATA: begin
          aw_ready = 1'b1;
          if (S_AXI_AWVALID) begin
            commit     = 1'b1;
            commit_idx = aw_idx_in;
            w_next     = W_RESP;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) w_next = W_IDLE;
        end
        default: w_next = W_IDLE;
      endcase
    end
  end

  assign commit_sel = decode(commit_idx);

  // NOTE: the register file is a handful of flops that drive reg_out directly, so it is reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int k = 0; k < C_NUM_REGS; k++) regs[k] <= '0;
      aw_idx_q     <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      bresp_q      <= RESP_OKAY;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= commit ? commit_sel : '0;
      if (capture_aw) aw_idx_q <= aw_idx_in;
      if (capture_w) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        bresp_q <= (|commit_sel) ? RESP_OKAY : RESP_SLVERR;
        for (int k = 0; k < C_NUM_REGS; k++) begin
          if (commit_sel[k]) regs[k] <= apply_wstrb(regs[k], commit_data, commit_strb);
        end
      end
    end
  end

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = w_ready;
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BRESP   = bresp_q;

  // ----------------------------------------------------------------- read FSM
  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next   = r_state;
    ar_ready = 1'b0;
    ar_fire  = 1'b0;
    if (!ARESET) begin
      unique case (r_state)
        R_IDLE: begin
          ar_ready = 1'b1;
          if (S_AXI_ARVALID) begin
            ar_fire = 1'b1;
            r_next  = R_RESP;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) r_next = R_IDLE;
        end
        default: r_next = R_IDLE;
      endcase
    end
  end

  assign rd_sel = decode(ar_idx_in);

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      if (rd_sel[k]) rd_word = regs[k];
    end
  end

  // Sampling regs here sees the pre-commit value when a write lands on the same edge.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_fire) begin
      rdata_q <= rd_word;
      rresp_q <= (|rd_sel) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_RVALID  = (r_state == R_RESP);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_reg_out
    assign reg_out[k*C_DATA_WIDTH +: C_DATA_WIDTH] = regs[k];
  end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Scoreboard bench for axi4lite_reg_slave: expected B/R responses are queued
// when a transaction is issued and compared when the slave returns them.
`timescale 1ns/1ps
module tb_axi4lite_reg_slave;
  import axi4lite_reg_pkg::*;

  localparam int NREG = 4;
  localparam int AW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              areset;
  logic [AW-1:0]     awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [31:0]       wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;
  logic [NREG*32-1:0] reg_out;
  logic [NREG-1:0]   reg_wr_pulse;

  axi4lite_reg_slave #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(AW), .C_NUM_REGS(NREG)) dut (
    .ACLK(clk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model and scoreboard queues
  logic [31:0] model [NREG];
  int          exp_pulse [NREG];
  int          pulse_cnt [NREG];
  logic [1:0]  b_q [$];
  logic [33:0] r_q [$];
  logic [33:0] mon_r;

  function automatic logic [NREG*32-1:0] model_vec();
    logic [NREG*32-1:0] v;
    for (int k = 0; k < NREG; k++) v[k*32 +: 32] = model[k];
    return v;
  endfunction

  always @(negedge clk) begin
    if (!areset) begin
      for (int k = 0; k < NREG; k++) if (reg_wr_pulse[k]) pulse_cnt[k]++;
      if (bvalid && bready) begin
        if (b_q.size() == 0) check("b_unexpected", {bvalid, bready}, 2'b00);
        else check("bresp", bresp, b_q.pop_front());
      end
      if (rvalid && rready) begin
        if (r_q.size() == 0) check("r_unexpected", {rvalid, rready}, 2'b00);
        else begin
          mon_r = r_q.pop_front();
          check("rdata", rdata, mon_r[33:2]);
          check("rresp", rresp, mon_r[1:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Callers start aligned just after a rising edge; returns just after the commit edge.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, output int aw_cyc);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_hs, w_hs;
    int cyc = 0;
    int idx;
    idx = int'(addr[AW-1:2]);
    b_q.push_back(idx < NREG ? RESP_OKAY : RESP_SLVERR);
    aw_cyc = -1;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done)) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      step();
      if (aw_hs) begin aw_done = 1'b1; aw_cyc = cyc; end
      if (w_hs) w_done = 1'b1;
      cyc++;
      if (!(aw_done && w_done) && cyc > 60) begin
        check("write_timeout", {aw_done, w_done}, 2'b11);
        break;
      end
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (idx < NREG) begin
      model[idx] = apply_wstrb(model[idx], data, strb);
      exp_pulse[idx]++;
    end
  endtask

  // Expectation is taken from the model at issue time; returns after the R handshake edge.
  task automatic axi_read(input logic [AW-1:0] addr, input int ar_dly, output int ar_cyc);
    bit ar_hs = 1'b0;
    int cyc = 0;
    int idx;
    idx = int'(addr[AW-1:2]);
    r_q.push_back(idx < NREG ? {model[idx], RESP_OKAY} : {32'h0, RESP_SLVERR});
    ar_cyc = -1;
    araddr = addr;
    while (!ar_hs) begin
      arvalid = (cyc >= ar_dly);
      @(negedge clk);
      ar_hs = arvalid && arready;
      step();
      if (ar_hs) ar_cyc = cyc;
      cyc++;
      if (!ar_hs && cyc > 60) begin
        check("read_timeout", ar_hs, 1'b1);
        break;
      end
    end
    arvalid = 1'b0;
    @(negedge clk);
    check("rvalid_latency", rvalid, 1'b1);
    step();
  endtask

  task automatic drain();
    int n = 0;
    while ((b_q.size() != 0 || r_q.size() != 0) && n < 50) begin
      step();
      n++;
    end
    check("drain", b_q.size() + r_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c2;
    int snap [NREG];
    logic [NREG*32-1:0] snap_vec;

    areset = 1'b1;
    awaddr = '0; awprot = 3'b010; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = 3'b001; arvalid = 1'b0; rready = 1'b1;
    for (int k = 0; k < NREG; k++) begin model[k] = '0; exp_pulse[k] = 0; pulse_cnt[k] = 0; end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_reg_out", reg_out, '0);
    check("rst_rdata", rdata, '0);
    check("rst_bresp", bresp, 2'b00);
    check("rst_rresp", rresp, 2'b00);
    check("rst_pulse", reg_wr_pulse, '0);
    step();
    areset = 1'b0;
    step();

    // Simultaneous AW/W writes then read-back
    for (int k = 0; k < NREG; k++) axi_write(AW'(4*k), 32'(k + 1), 4'hF, 0, 0, c);
    drain();
    for (int k = 0; k < NREG; k++) axi_read(AW'(4*k), 0, c);
    drain();
    check("basic_reg_out", reg_out, {32'h4, 32'h3, 32'h2, 32'h1});

    // W two cycles ahead of AW, BREADY held low
    c2 = pulse_cnt[1];
    bready = 1'b0;
    axi_write(5'h04, 32'hCAFE_0001, 4'hF, 2, 0, c);
    check("aw_after_w_cycle", c, 2);
    repeat (3) begin
      @(negedge clk);
      check("bvalid_held", bvalid, 1'b1);
      check("bresp_stable", bresp, RESP_OKAY);
      check("resp_readies", {awready, wready}, 2'b00);
    end
    check("reg1_updated", reg_out[63:32], 32'hCAFE_0001);
    step();
    bready = 1'b1;
    drain();
    check("pulse1_once", pulse_cnt[1] - c2, 1);

    // Byte strobes and an empty strobe
    axi_write(5'h08, 32'hAABB_CCDD, 4'hF, 0, 0, c);
    axi_write(5'h08, 32'h1122_3344, 4'b0101, 0, 0, c);
    c2 = pulse_cnt[3];
    axi_write(5'h0C, 32'hFFFF_FFFF, 4'b0000, 0, 0, c);
    drain();
    check("strobe_merge", reg_out[95:64], 32'hAA22_CC44);
    check("zero_strobe_data", reg_out[127:96], 32'h4);
    check("zero_strobe_pulse", pulse_cnt[3] - c2, 1);

    // Unmapped write/read, then byte offset ignored
    snap_vec = reg_out;
    for (int k = 0; k < NREG; k++) snap[k] = pulse_cnt[k];
    axi_write(5'h10, 32'hDEAD_BEEF, 4'hF, 1, 0, c);
    axi_read(5'h1C, 0, c);
    drain();
    check("unmapped_no_change", reg_out, snap_vec);
    for (int k = 0; k < NREG; k++) check("unmapped_no_pulse", pulse_cnt[k] - snap[k], 0);
    axi_write(5'h07, 32'h0000_7777, 4'hF, 0, 1, c);
    axi_read(5'h06, 0, c);
    drain();
    check("offset_ignored", reg_out[63:32], 32'h0000_7777);

    // Back-to-back acceptance
    axi_write(5'h00, 32'h0000_0100, 4'hF, 0, 0, c);
    axi_write(5'h04, 32'h0000_0200, 4'hF, 0, 0, c2);
    check("b2b_write_accept", c2, 1);
    axi_read(5'h00, 0, c);
    axi_read(5'h04, 0, c2);
    check("b2b_read_accept", c2, 0);
    drain();

    // Read and write to the same register on the same edge
    fork
      axi_write(5'h00, 32'h0000_0005, 4'hF, 0, 0, c);
      axi_read(5'h00, 0, c2);
    join
    drain();
    axi_read(5'h00, 0, c);
    drain();
    check("same_edge_new_value", reg_out[31:0], 32'h5);
    check("model_reg_out", reg_out, model_vec());

    // Reset while holding a captured address and a pending read response
    rready = 1'b0;
    awaddr = 5'h08; awvalid = 1'b1;
    araddr = 5'h00; arvalid = 1'b1;
    step();
    awvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("mid_have_addr", {awready, wready}, 2'b01);
    check("mid_r_resp", rvalid, 1'b1);
    for (int k = 0; k < NREG; k++) snap[k] = pulse_cnt[k];
    step();
    areset = 1'b1;
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    check("rst_mid_readies", {awready, wready, arready}, 3'b000);
    step();
    areset = 1'b0;
    wvalid = 1'b0;
    rready = 1'b1;
    for (int k = 0; k < NREG; k++) model[k] = '0;
    @(negedge clk);
    check("rst_mid_regs", reg_out, '0);
    check("rst_mid_valids", {bvalid, rvalid}, 2'b00);
    check("rst_mid_rdata", rdata, '0);
    check("rst_mid_pulse", reg_wr_pulse, '0);
    step();
    repeat (3) step();
    for (int k = 0; k < NREG; k++) check("rst_mid_no_commit", pulse_cnt[k] - snap[k], 0);
    check("rst_mid_no_b", b_q.size(), 0);

    // Recovery after reset
    axi_write(5'h04, 32'h0000_0099, 4'hF, 0, 0, c);
    axi_read(5'h04, 0, c);
    drain();
    check("recover_reg1", reg_out[63:32], 32'h99);

    for (int k = 0; k < NREG; k++) check("pulse_total", pulse_cnt[k], exp_pulse[k]);
    check("final_reg_out", reg_out, model_vec());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
